// File: rtl/i2c_slave_responder.sv
// rtl/i2c_slave_responder.sv - I2C target bridging pointer writes and reads to a byte register port
// Optional build macro: I2C_SLV_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module i2c_slave_responder #(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         PTR_W    = 8
) (
  input  logic             clk,
  input  logic             s_resetn,
  input  logic             i2c_scl,
  input  logic             i2c_sda_i,
  output logic             i2c_sda_oe,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
    IGNORE    = 4'd9
  } state_t;

  logic [1:0]       scl_sync, sda_sync;
  logic             scl_c, sda_c, scl_q, sda_q;
  logic             scl_rise, scl_fall, start_det, stop_det;
  state_t           state;
  logic [3:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [7:0]       rx_byte;
  logic [PTR_W-1:0] ptr;
  logic             rw, mack;

  // Two-flop synchronizers, reset to the idle bus level so leaving reset is quiet
  always_ff @(posedge clk or negedge s_resetn) begin
    if (!s_resetn) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], i2c_scl};
      sda_sync <= {sda_sync[0], i2c_sda_i};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;
  logic       scl_flt, sda_flt;

  // Majority of the last three synchronized samples swallows single-cycle pulses
  always_ff @(posedge clk or negedge s_resetn) begin
    if (!s_resetn) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_flt  <= 1'b1;
      sda_flt  <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_flt  <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
      sda_flt  <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
    end
  end

  assign scl_c = scl_flt;
  assign sda_c = sda_flt;
`else
  assign scl_c = scl_sync[1];
  assign sda_c = sda_sync[1];
`endif

  // Previous conditioned levels for edge and START/STOP detection
  always_ff @(posedge clk or negedge s_resetn) begin
    if (!s_resetn) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_c;
      sda_q <= sda_c;
    end
  end

  assign scl_rise  = scl_c & ~scl_q;
  assign scl_fall  = ~scl_c & scl_q;
  assign start_det = scl_c & scl_q & sda_q & ~sda_c;
  assign stop_det  = scl_c & scl_q & ~sda_q & sda_c;
  assign rx_byte   = {shreg[6:0], sda_c};
  assign rd_addr   = ptr;

  // Protocol FSM; SDA drive only moves on a detected SCL fall so it never changes while SCL is high
  always_ff @(posedge clk or negedge s_resetn) begin
    if (!s_resetn) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= 8'd0;
      ptr        <= '0;
      rw         <= 1'b0;
      mack       <= 1'b0;
      i2c_sda_oe <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'd0;
      busy       <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      if (stop_det) begin
        state      <= IDLE;
        bit_cnt    <= 4'd0;
        i2c_sda_oe <= 1'b0;
        busy       <= 1'b0;
      end else if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (state == WDATA && bit_cnt == 4'd7) begin
                wr_valid <= 1'b1;
                wr_addr  <= ptr;
                wr_data  <= rx_byte;
                ptr      <= ptr + PTR_W'(1);
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              case (state)
                ADDR: begin
                  // General call (0x00) is never claimed
                  if (shreg[7:1] == SLV_ADDR && shreg[7:1] != 7'd0) begin
                    state      <= ADDR_ACK;
                    rw         <= shreg[0];
                    i2c_sda_oe <= 1'b1;
                    busy       <= 1'b1;
                  end else begin
                    state <= IGNORE;
                    busy  <= 1'b0;
                  end
                end
                PTR: begin
                  ptr        <= PTR_W'(shreg);
                  state      <= PTR_ACK;
                  i2c_sda_oe <= 1'b1;
                end
                default: begin
                  state      <= WDATA_ACK;
                  i2c_sda_oe <= 1'b1;
                end
              endcase
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              bit_cnt    <= 4'd0;
              i2c_sda_oe <= 1'b0;
              if (state == ADDR_ACK && rw) begin
                state      <= RDATA;
                shreg      <= rd_data;
                i2c_sda_oe <= ~rd_data[7];
              end else if (state == ADDR_ACK) begin
                state <= PTR;
              end else begin
                state <= WDATA;
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt != 4'd0) begin
              if (bit_cnt == 4'd8) begin
                state      <= RDATA_ACK;
                bit_cnt    <= 4'd0;
                mack       <= 1'b0;
                i2c_sda_oe <= 1'b0;
              end else begin
                shreg      <= {shreg[6:0], 1'b0};
                i2c_sda_oe <= ~shreg[6];
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              mack <= ~sda_c;
              if (!sda_c) ptr <= ptr + PTR_W'(1);
            end else if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (mack) begin
                state      <= RDATA;
                shreg      <= rd_data;
                i2c_sda_oe <= ~rd_data[7];
              end else begin
                state      <= IGNORE;
                i2c_sda_oe <= 1'b0;
                busy       <= 1'b0;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb/tb_i2c_slave_responder.sv - directed self-checking bench for i2c_slave_responder
module tb_i2c_slave_responder;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       s_resetn = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       i2c_sda_i, i2c_sda_oe, wr_valid, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  int checks = 0;
  int fails = 0;

  logic [7:0] wr_a_log [16];
  logic [7:0] wr_d_log [16];
  int wr_n = 0;
  int oe_hi_changes = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  int addr_cnt = 0;
  logic prev_oe = 1'b0;

  i2c_slave_responder dut (
    .clk        (clk),
    .s_resetn   (s_resetn),
    .i2c_scl    (scl),
    .i2c_sda_i  (i2c_sda_i),
    .i2c_sda_oe (i2c_sda_oe),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Open-drain bus: low if either side pulls
  assign i2c_sda_i = m_sda & ~i2c_sda_oe;
  // Register file model: each register holds the complement of its address
  assign rd_data = rd_addr ^ 8'hFF;

  // Bus observer: write log, SDA-drive activity, busy and ADDR-state occupancy
  always @(negedge clk) begin
    if (wr_valid) begin
      if (wr_n < 16) begin
        wr_a_log[wr_n] = wr_addr;
        wr_d_log[wr_n] = wr_data;
      end
      wr_n++;
    end
    if (s_resetn && scl && (i2c_sda_oe !== prev_oe)) oe_hi_changes++;
    prev_oe = i2c_sda_oe;
    if (i2c_sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
    if (dut.state == 4'd1) addr_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b0; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_rstart();
    m_sda = 1'b1; tick(Q); scl = 1'b1; tick(Q); m_sda = 1'b0; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q); scl = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b, output logic bus);
    m_sda = b; tick(Q); scl = 1'b1; tick(Q); bus = i2c_sda_i; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic bus;
    for (int i = 7; i >= 0; i--) send_bit(b[i], bus);
    send_bit(1'b1, bus);
    ack = ~bus;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic bus;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, bus);
      d[i] = bus;
    end
    send_bit(nack, bus);
  endtask

  task automatic test_reset();
    s_resetn = 1'b0; tick(4);
    checks++; if (i2c_sda_oe !== 1'b0) begin fails++; $display("FAIL reset_oe: got %b want 0", i2c_sda_oe); end
    checks++; if (wr_valid !== 1'b0) begin fails++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
    checks++; if (wr_addr !== 8'h00) begin fails++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin fails++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    checks++; if (rd_addr !== 8'h00) begin fails++; $display("FAIL reset_rd_addr: got %h want 00", rd_addr); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    s_resetn = 1'b1; tick(Q);
  endtask

  task automatic test_write();
    logic [7:0] bytes [4];
    logic ack;
    int n0;
    bytes = '{8'hA0, 8'h10, 8'hA5, 8'h3C};
    n0 = wr_n;
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(bytes[i], ack);
      checks++; if (ack !== 1'b1) begin fails++; $display("FAIL write_ack%0d: got %b want 1", i, ack); end
    end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL write_busy_mid: got %b want 1", busy); end
    i2c_stop(); tick(Q);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL write_busy_end: got %b want 0", busy); end
    checks++; if (wr_n - n0 !== 2) begin fails++; $display("FAIL write_count: got %0d want 2", wr_n - n0); end
    if (wr_n - n0 == 2) begin
      checks++; if (wr_a_log[n0] !== 8'h10) begin fails++; $display("FAIL write_addr0: got %h want 10", wr_a_log[n0]); end
      checks++; if (wr_d_log[n0] !== 8'hA5) begin fails++; $display("FAIL write_data0: got %h want a5", wr_d_log[n0]); end
      checks++; if (wr_a_log[n0+1] !== 8'h11) begin fails++; $display("FAIL write_addr1: got %h want 11", wr_a_log[n0+1]); end
      checks++; if (wr_d_log[n0+1] !== 8'h3C) begin fails++; $display("FAIL write_data1: got %h want 3c", wr_d_log[n0+1]); end
    end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d;
    int n0;
    n0 = wr_n;
    i2c_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) begin fails++; $display("FAIL read_waddr_ack: got %b want 1", ack); end
    write_byte(8'h20, ack);
    checks++; if (ack !== 1'b1) begin fails++; $display("FAIL read_ptr_ack: got %b want 1", ack); end
    i2c_rstart();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1) begin fails++; $display("FAIL read_raddr_ack: got %b want 1", ack); end
    read_byte(d, 1'b0);
    checks++; if (d !== 8'hDF) begin fails++; $display("FAIL read_byte0: got %h want df", d); end
    read_byte(d, 1'b1);
    checks++; if (d !== 8'hDE) begin fails++; $display("FAIL read_byte1: got %h want de", d); end
    tick(Q);
    checks++; if (i2c_sda_oe !== 1'b0) begin fails++; $display("FAIL read_release: got %b want 0", i2c_sda_oe); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL read_busy_after_nack: got %b want 0", busy); end
    checks++; if (rd_addr !== 8'h21) begin fails++; $display("FAIL read_ptr_after: got %h want 21", rd_addr); end
    i2c_stop(); tick(Q);
    checks++; if (wr_n !== n0) begin fails++; $display("FAIL read_no_writes: got %0d want %0d", wr_n, n0); end
  endtask

  task automatic test_nomatch();
    logic ack;
    int n0, oe0, b0;
    n0 = wr_n; oe0 = oe_cnt; b0 = busy_cnt;
    i2c_start();
    write_byte(8'hA2, ack);
    checks++; if (ack !== 1'b0) begin fails++; $display("FAIL nomatch_ack: got %b want 0", ack); end
    write_byte(8'h55, ack);
    i2c_stop(); tick(Q);
    checks++; if (oe_cnt !== oe0) begin fails++; $display("FAIL nomatch_oe: got %0d driven cycles want 0", oe_cnt - oe0); end
    checks++; if (busy_cnt !== b0) begin fails++; $display("FAIL nomatch_busy: got %0d busy cycles want 0", busy_cnt - b0); end
    checks++; if (wr_n !== n0) begin fails++; $display("FAIL nomatch_writes: got %0d want %0d", wr_n, n0); end
  endtask

  task automatic test_wrap();
    logic [7:0] bytes [4];
    logic ack;
    int n0;
    bytes = '{8'hA0, 8'hFF, 8'h11, 8'h22};
    n0 = wr_n;
    i2c_start();
    for (int i = 0; i < 4; i++) write_byte(bytes[i], ack);
    i2c_stop(); tick(Q);
    checks++; if (wr_n - n0 !== 2) begin fails++; $display("FAIL wrap_count: got %0d want 2", wr_n - n0); end
    if (wr_n - n0 == 2) begin
      checks++; if (wr_a_log[n0] !== 8'hFF) begin fails++; $display("FAIL wrap_addr0: got %h want ff", wr_a_log[n0]); end
      checks++; if (wr_a_log[n0+1] !== 8'h00) begin fails++; $display("FAIL wrap_addr1: got %h want 00", wr_a_log[n0+1]); end
      checks++; if (wr_d_log[n0+1] !== 8'h22) begin fails++; $display("FAIL wrap_data1: got %h want 22", wr_d_log[n0+1]); end
    end
  endtask

  task automatic test_reset_mid();
    logic ack, bus;
    logic [7:0] a;
    logic [7:0] d;
    a = 8'hA1;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h05, ack);
    i2c_rstart();
    for (int i = 7; i >= 0; i--) send_bit(a[i], bus);
    m_sda = 1'b1; tick(Q);
    checks++; if (i2c_sda_oe !== 1'b1) begin fails++; $display("FAIL rstmid_ack_driven: got %b want 1", i2c_sda_oe); end
    s_resetn = 1'b0; #1;
    checks++; if (i2c_sda_oe !== 1'b0) begin fails++; $display("FAIL rstmid_async_release: got %b want 0", i2c_sda_oe); end
    tick(2); scl = 1'b1; tick(4);
    s_resetn = 1'b1; tick(Q);
    checks++; if (rd_addr !== 8'h00) begin fails++; $display("FAIL rstmid_ptr: got %h want 00", rd_addr); end
    i2c_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1) begin fails++; $display("FAIL rstmid_addr_ack: got %b want 1", ack); end
    read_byte(d, 1'b1);
    checks++; if (d !== 8'hFF) begin fails++; $display("FAIL rstmid_read: got %h want ff", d); end
    i2c_stop(); tick(Q);
  endtask

  task automatic test_glitch();
    int a0, exp_seen;
`ifdef I2C_SLV_GLITCH_FILTER_EN
    exp_seen = 0;
`else
    exp_seen = 1;
`endif
    a0 = addr_cnt;
    m_sda = 1'b0; tick(1); m_sda = 1'b1; tick(12);
    checks++; if ((addr_cnt > a0 ? 1 : 0) !== exp_seen) begin fails++; $display("FAIL glitch_start: got %0d want %0d", (addr_cnt > a0 ? 1 : 0), exp_seen); end
    checks++; if (dut.state != 4'd0) begin fails++; $display("FAIL glitch_idle: got %0d want 0", dut.state); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %b want 0", busy); end
  endtask

  task automatic test_oe_stable();
    checks++; if (oe_hi_changes !== 0) begin fails++; $display("FAIL oe_while_scl_high: got %0d changes want 0", oe_hi_changes); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nomatch();
    test_wrap();
    test_reset_mid();
    test_glitch();
    test_oe_stable();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
